seq_match_tally: RTL and testbench

//  Downstream consumer of the 0000/1111 sequence-detector output.
//  - Samples detector output z and input bit w on each step strobe.
//  - Counts distinct match runs separately for all-zeros and all-ones matches.
//  - Tracks the longest match run.
//  - Drives four active-low 7-segment digits: HEX1:HEX0 = zeros count, HEX3:HEX2 = ones count.

---
 rtl/seq_match_tally_if.sv | 39 +++
 rtl/seq_match_tally.sv | 120 ++++++++++++
 tb/tb_seq_match_tally.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/seq_match_tally_if.sv
// Purpose: bundles the sample/clear inputs and all result outputs of
//          seq_match_tally so the block connects through one port.
// Ports (signals):
//   i_sample_en, i_w, i_z, i_clr        : detector step strobe, bit, match, clear
//   o_cnt0_bcd, o_cnt1_bcd               : zeros/ones run counts, 2-digit BCD
//   o_max_run                            : longest run seen, in samples
//   o_match_event, o_match_pol, o_state  : run-start pulse, its polarity, FSM state
//   o_hex0..o_hex3                       : active-low 7-segment digits {g,f,e,d,c,b,a}
// Modports: slave = the tally block, master = whatever drives and observes it.
interface seq_match_tally_if #(
  parameter int RUN_W = 8
);
  logic             i_sample_en;
  logic             i_w;
  logic             i_z;
  logic             i_clr;
  logic [7:0]       o_cnt0_bcd;
  logic [7:0]       o_cnt1_bcd;
  logic [RUN_W-1:0] o_max_run;
  logic             o_match_event;
  logic             o_match_pol;
  logic [1:0]       o_state;
  logic [6:0]       o_hex0;
  logic [6:0]       o_hex1;
  logic [6:0]       o_hex2;
  logic [6:0]       o_hex3;

  modport slave (
    input  i_sample_en, i_w, i_z, i_clr,
    output o_cnt0_bcd, o_cnt1_bcd, o_max_run, o_match_event, o_match_pol,
           o_state, o_hex0, o_hex1, o_hex2, o_hex3
  );

  modport master (
    output i_sample_en, i_w, i_z, i_clr,
    input  o_cnt0_bcd, o_cnt1_bcd, o_max_run, o_match_event, o_match_pol,
           o_state, o_hex0, o_hex1, o_hex2, o_hex3
  );
endinterface

// File: rtl/seq_match_tally.sv
// Purpose: consumer of a 0000/1111 sequence detector. On each step strobe it
//          samples {z,w}, counts distinct all-zeros and all-ones match runs in
//          saturating BCD, tracks the longest run, and shows both counts on
//          four active-low 7-segment digits (HEX1:HEX0 zeros, HEX3:HEX2 ones).
// Ports:
//   clock  : system clock, rising edge
//   resetn : synchronous active-low reset, overrides everything
//   bus    : seq_match_tally_if.slave (inputs i_*, outputs o_*)
//
// state | meaning
// IDLE  | no match run in progress (last sample had z=0, or after reset/clear)
// M0    | inside an all-zeros match run
// M1    | inside an all-ones match run
module seq_match_tally #(
  parameter int MAX_COUNT = 99,
  parameter int RUN_W     = 8
) (
  input  logic                clock,
  input  logic                resetn,
  seq_match_tally_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    M0   = 2'b01,
    M1   = 2'b10
  } state_t;

  localparam logic [7:0]       MAX_BCD = {4'(MAX_COUNT / 10), 4'(MAX_COUNT % 10)};
  localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  state_t           r_state;
  logic [7:0]       r_cnt0;
  logic [7:0]       r_cnt1;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] r_max_run;
  logic             r_match_event;
  logic             r_match_pol;

  logic [RUN_W-1:0] w_run_inc;
  logic             w_continue;

  // Saturating 2-digit BCD increment; holds once MAX_COUNT is reached.
  function automatic logic [7:0] bcd_inc(input logic [7:0] c);
    if (c == MAX_BCD)
      return c;
    else if (c[3:0] == 4'd9)
      return {c[7:4] + 4'd1, 4'd0};
    else
      return {c[7:4], c[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  assign w_run_inc  = (r_run == RUN_MAX) ? r_run : r_run + RUN_ONE;
  // Same polarity as the run in progress extends it; anything else with z=1 starts a new run.
  assign w_continue = (bus.i_w && r_state == M1) || (!bus.i_w && r_state == M0);

  always_ff @(posedge clock) begin
    if (!resetn || bus.i_clr) begin
      r_state       <= IDLE;
      r_cnt0        <= 8'h00;
      r_cnt1        <= 8'h00;
      r_run         <= '0;
      r_max_run     <= '0;
      r_match_event <= 1'b0;
      r_match_pol   <= 1'b0;
    end else begin
      r_match_event <= 1'b0;
      if (bus.i_sample_en) begin
        if (!bus.i_z) begin
          r_state <= IDLE;
          r_run   <= '0;
        end else if (w_continue) begin
          r_run <= w_run_inc;
          if (w_run_inc > r_max_run)
            r_max_run <= w_run_inc;
        end else begin
          r_state       <= bus.i_w ? M1 : M0;
          r_run         <= RUN_ONE;
          r_match_event <= 1'b1;
          r_match_pol   <= bus.i_w;
          if (r_max_run == '0)
            r_max_run <= RUN_ONE;
          if (bus.i_w)
            r_cnt1 <= bcd_inc(r_cnt1);
          else
            r_cnt0 <= bcd_inc(r_cnt0);
        end
      end
    end
  end

  assign bus.o_cnt0_bcd    = r_cnt0;
  assign bus.o_cnt1_bcd    = r_cnt1;
  assign bus.o_max_run     = r_max_run;
  assign bus.o_match_event = r_match_event;
  assign bus.o_match_pol   = r_match_pol;
  assign bus.o_state       = r_state;
  assign bus.o_hex0        = seg7(r_cnt0[3:0]);
  assign bus.o_hex1        = seg7(r_cnt0[7:4]);
  assign bus.o_hex2        = seg7(r_cnt1[3:0]);
  assign bus.o_hex3        = seg7(r_cnt1[7:4]);

endmodule

// File: tb/tb_seq_match_tally.sv
// Purpose: directed test of seq_match_tally against an integer-level model of
//          the run-counting rules, plus literal expectations at key points.
module tb_seq_match_tally;

  logic clock;
  logic resetn;

  seq_match_tally_if #(.RUN_W(8)) bus ();

  seq_match_tally #(.MAX_COUNT(99), .RUN_W(8)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // model: mode 0 = no run, 1 = zeros run, 2 = ones run
  int m_mode, m_cnt0, m_cnt1, m_run, m_max, m_ev, m_pol;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int c);
    return 8'((c / 10) * 16 + (c % 10));
  endfunction

  always @(posedge clock) begin
    if (!resetn || bus.i_clr) begin
      m_mode = 0; m_cnt0 = 0; m_cnt1 = 0; m_run = 0; m_max = 0; m_ev = 0; m_pol = 0;
    end else if (bus.i_sample_en) begin
      m_ev = 0;
      if (!bus.i_z) begin
        m_mode = 0;
        m_run  = 0;
      end else if (m_mode == int'(bus.i_w) + 1) begin
        m_run = (m_run < 255) ? m_run + 1 : 255;
      end else begin
        m_mode = int'(bus.i_w) + 1;
        m_run  = 1;
        m_ev   = 1;
        m_pol  = int'(bus.i_w);
        if (bus.i_w) m_cnt1 = (m_cnt1 < 99) ? m_cnt1 + 1 : 99;
        else         m_cnt0 = (m_cnt0 < 99) ? m_cnt0 + 1 : 99;
      end
      if (m_run > m_max) m_max = m_run;
    end else begin
      m_ev = 0;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("m_cnt0", bus.o_cnt0_bcd, to_bcd(m_cnt0));
      chk("m_cnt1", bus.o_cnt1_bcd, to_bcd(m_cnt1));
      chk("m_max_run", bus.o_max_run, m_max);
      chk("m_event", bus.o_match_event, m_ev);
      chk("m_pol", bus.o_match_pol, m_pol);
      chk("m_state", bus.o_state, m_mode);
      chk("m_hex0", bus.o_hex0, SEG[m_cnt0 % 10]);
      chk("m_hex1", bus.o_hex1, SEG[m_cnt0 / 10]);
      chk("m_hex2", bus.o_hex2, SEG[m_cnt1 % 10]);
      chk("m_hex3", bus.o_hex3, SEG[m_cnt1 / 10]);
    end
  end

  int ev_cnt;

  task automatic step(input logic rn, input logic se, input logic z, input logic w, input logic c);
    resetn          = rn;
    bus.i_sample_en = se;
    bus.i_z         = z;
    bus.i_w         = w;
    bus.i_clr       = c;
    @(posedge clock);
    @(negedge clock);
    ev_cnt += int'(bus.o_match_event);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cnt0"}, bus.o_cnt0_bcd, 8'h00);
    chk({tag, "_cnt1"}, bus.o_cnt1_bcd, 8'h00);
    chk({tag, "_max"}, bus.o_max_run, 8'd0);
    chk({tag, "_state"}, bus.o_state, 2'b00);
    chk({tag, "_event"}, bus.o_match_event, 1'b0);
    chk({tag, "_pol"}, bus.o_match_pol, 1'b0);
    chk({tag, "_hex0"}, bus.o_hex0, 7'b1000000);
    chk({tag, "_hex3"}, bus.o_hex3, 7'b1000000);
  endtask

  initial begin
    ev_cnt = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_en = 1'b1;
    chk_reset_vals("reset");

    // 1: four zeros-match samples
    ev_cnt = 0;
    repeat (4) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_cnt0", bus.o_cnt0_bcd, 8'h01);
    chk("t1_state", bus.o_state, 2'b01);
    chk("t1_max", bus.o_max_run, 8'd4);
    chk("t1_hex0", bus.o_hex0, 7'b1111001);
    chk("t1_pulses", ev_cnt, 1);

    // 2: switch to ones run
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t2_state", bus.o_state, 2'b10);
    chk("t2_cnt1", bus.o_cnt1_bcd, 8'h01);
    chk("t2_pol", bus.o_match_pol, 1'b1);
    chk("t2_event", bus.o_match_event, 1'b1);
    chk("t2_max", bus.o_max_run, 8'd4);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t2_event_off", bus.o_match_event, 1'b0);

    // 3: 100 separate zeros runs after a clear
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 100; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      if (k == 9)   chk("t3_cnt_09", bus.o_cnt0_bcd, 8'h09);
      if (k == 10)  chk("t3_cnt_10", bus.o_cnt0_bcd, 8'h10);
      if (k == 98)  chk("t3_cnt_98", bus.o_cnt0_bcd, 8'h98);
      if (k == 99)  chk("t3_cnt_99", bus.o_cnt0_bcd, 8'h99);
      if (k == 100) chk("t3_cnt_hold", bus.o_cnt0_bcd, 8'h99);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (k == 50) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("t3_hex1", bus.o_hex1, 7'b0010000);
    chk("t3_hex0", bus.o_hex0, 7'b0010000);
    chk("t3_max", bus.o_max_run, 8'd1);
    chk("t3_state", bus.o_state, 2'b00);

    // 4: clear with coincident sample
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk_reset_vals("t4");

    // 5: reset mid-run in M1 with run=3
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_state", bus.o_state, 2'b10);
    chk("t5_max", bus.o_max_run, 8'd3);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_reset_vals("t5");

    // 6: ones held, strobe every third cycle
    for (int i = 1; i <= 300; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      if (i == 10) chk("t6_max_10", bus.o_max_run, 8'd10);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      if (i == 10) chk("t6_max_hold", bus.o_max_run, 8'd10);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    chk("t6_max", bus.o_max_run, 8'd255);
    chk("t6_cnt1", bus.o_cnt1_bcd, 8'h01);

    // ones run straight into a zeros run
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t7_state", bus.o_state, 2'b01);
    chk("t7_cnt0", bus.o_cnt0_bcd, 8'h01);
    chk("t7_pol", bus.o_match_pol, 1'b0);
    chk("t7_event", bus.o_match_event, 1'b1);
    chk("t7_max", bus.o_max_run, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
